// File: rtl/ln_pkg.sv
// rtl/ln_pkg.sv - shared parameters and FSM state type for the layer-norm row sequencer
package ln_pkg;

   localparam int LANES        = 64;
   localparam int DW           = 16;
   localparam int ROW_W        = LANES * DW;
   localparam int STAT_TIMEOUT = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STAT,
      ST_NORM,
      ST_WAIT_RES,
      ST_OUT,
      ST_DONE
   } ln_seq_state_t;

endpackage

// File: rtl/ln_timeout_cnt.sv
// rtl/ln_timeout_cnt.sv - wait counter that flags the cycle in which LIMIT enabled cycles are reached
module ln_timeout_cnt #(
   parameter  int LIMIT = 255,
   localparam int CW    = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1)
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Expires in the LIMIT-th enabled cycle, so the owner reacts exactly LIMIT cycles after entry.
   assign expired = enable && ((32'(cnt_q) + 32'd1) >= 32'(LIMIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ln_row_sequencer.sv
// rtl/ln_row_sequencer.sv - sequences rows through statistics and normalizer units with output handshake
module ln_row_sequencer #(
   parameter  int LANES        = ln_pkg::LANES,
   parameter  int DW           = ln_pkg::DW,
   parameter  int STAT_TIMEOUT = ln_pkg::STAT_TIMEOUT,
   localparam int ROW_W        = LANES * DW
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [15:0]      i_cfg_rows,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [15:0]      o_row_cnt,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [ROW_W-1:0] i_in_data,
   output logic             o_stat_start,
   input  logic             i_stat_done,
   input  logic [31:0]      i_stat_mean,
   input  logic [16:0]      i_stat_inv_sqrt,
   output logic             o_norm_en,
   output logic             o_norm_trigger,
   output logic [31:0]      o_norm_mean,
   output logic [16:0]      o_norm_inv_sqrt,
   output logic [ROW_W-1:0] o_norm_raw,
   input  logic             i_norm_valid,
   input  logic [ROW_W-1:0] i_norm_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [ROW_W-1:0] o_out_data
);

   import ln_pkg::*;

   ln_seq_state_t    state_q, state_d;
   logic [15:0]      rows_q, rows_d;
   logic [15:0]      row_cnt_q, row_cnt_d;
   logic             err_q, err_d;
   logic             stat_start_q, stat_start_d;
   logic [ROW_W-1:0] row_buf_q, row_buf_d;
   logic [31:0]      mean_q, mean_d;
   logic [16:0]      inv_q, inv_d;
   logic [ROW_W-1:0] out_q, out_d;
   logic             stat_expired;

   ln_timeout_cnt #(
      .LIMIT (STAT_TIMEOUT)
   ) u_stat_timeout (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .clear   (state_q != ST_STAT),
      .enable  (state_q == ST_STAT),
      .expired (stat_expired)
   );

   always_comb begin
      state_d   = state_q;
      rows_d    = rows_q;
      row_cnt_d = row_cnt_q;
      err_d     = err_q;
      row_buf_d = row_buf_q;
      mean_d    = mean_q;
      inv_d     = inv_q;
      out_d     = out_q;
      // Abort beats every handshake that might coincide with it.
      if (i_abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  rows_d    = i_cfg_rows;
                  row_cnt_d = '0;
                  err_d     = 1'b0;
                  state_d   = (i_cfg_rows == 16'd0) ? ST_DONE : ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (i_in_valid) begin
                  row_buf_d = i_in_data;
                  state_d   = ST_STAT;
               end
            end
            ST_STAT: begin
               if (i_stat_done) begin
                  mean_d  = i_stat_mean;
                  inv_d   = i_stat_inv_sqrt;
                  state_d = ST_NORM;
               end else if (stat_expired) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_NORM: state_d = ST_WAIT_RES;
            ST_WAIT_RES: begin
               if (i_norm_valid) begin
                  out_d   = i_norm_data;
                  state_d = ST_OUT;
               end
            end
            ST_OUT: begin
               if (i_out_ready) begin
                  row_cnt_d = row_cnt_q + 16'd1;
                  state_d   = (row_cnt_d == rows_q) ? ST_DONE : ST_LOAD;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
      stat_start_d = (state_d == ST_STAT) && (state_q != ST_STAT);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         rows_q       <= '0;
         row_cnt_q    <= '0;
         err_q        <= 1'b0;
         stat_start_q <= 1'b0;
         row_buf_q    <= '0;
         mean_q       <= '0;
         inv_q        <= '0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         rows_q       <= rows_d;
         row_cnt_q    <= row_cnt_d;
         err_q        <= err_d;
         stat_start_q <= stat_start_d;
         row_buf_q    <= row_buf_d;
         mean_q       <= mean_d;
         inv_q        <= inv_d;
         out_q        <= out_d;
      end
   end

   assign o_busy          = (state_q != ST_IDLE);
   assign o_done          = (state_q == ST_DONE);
   assign o_err           = err_q;
   assign o_row_cnt       = row_cnt_q;
   assign o_in_ready      = (state_q == ST_LOAD);
   assign o_stat_start    = stat_start_q;
   assign o_norm_en       = o_busy;
   assign o_norm_trigger  = (state_q == ST_NORM);
   assign o_norm_mean     = mean_q;
   assign o_norm_inv_sqrt = inv_q;
   assign o_norm_raw      = row_buf_q;
   assign o_out_valid     = (state_q == ST_OUT);
   assign o_out_data      = out_q;

endmodule

// File: tb/tb_ln_row_sequencer.sv
// tb/tb_ln_row_sequencer.sv - self-checking bench for ln_row_sequencer
module tb_ln_row_sequencer;

   localparam int ROW_W = ln_pkg::ROW_W;

   logic             clk = 1'b0;
   logic             i_rst_n, i_start, i_abort;
   logic [15:0]      i_cfg_rows;
   logic             o_busy, o_done, o_err;
   logic [15:0]      o_row_cnt;
   logic             i_in_valid, o_in_ready;
   logic [ROW_W-1:0] i_in_data;
   logic             o_stat_start, i_stat_done;
   logic [31:0]      i_stat_mean;
   logic [16:0]      i_stat_inv_sqrt;
   logic             o_norm_en, o_norm_trigger;
   logic [31:0]      o_norm_mean;
   logic [16:0]      o_norm_inv_sqrt;
   logic [ROW_W-1:0] o_norm_raw;
   logic             i_norm_valid;
   logic [ROW_W-1:0] i_norm_data;
   logic             o_out_valid, i_out_ready;
   logic [ROW_W-1:0] o_out_data;

   int checks = 0;
   int errors = 0;
   logic [ROW_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   ln_row_sequencer dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
      .i_cfg_rows(i_cfg_rows), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .o_row_cnt(o_row_cnt), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_data(i_in_data), .o_stat_start(o_stat_start), .i_stat_done(i_stat_done),
      .i_stat_mean(i_stat_mean), .i_stat_inv_sqrt(i_stat_inv_sqrt), .o_norm_en(o_norm_en),
      .o_norm_trigger(o_norm_trigger), .o_norm_mean(o_norm_mean),
      .o_norm_inv_sqrt(o_norm_inv_sqrt), .o_norm_raw(o_norm_raw),
      .i_norm_valid(i_norm_valid), .i_norm_data(i_norm_data), .o_out_valid(o_out_valid),
      .i_out_ready(i_out_ready), .o_out_data(o_out_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_row(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed_low=%0h expected_low=%0h", tag, obs[63:0], exp[63:0]);
      end
   endtask

   function automatic logic [ROW_W-1:0] rand_row();
      logic [ROW_W-1:0] r;
      for (int w = 0; w < ROW_W / 32; w++) r[w*32 +: 32] = $urandom();
      return r;
   endfunction

   // One row through LOAD..OUT; the bench plays statistics unit and normalizer.
   task automatic do_row(input int idx, input int sdelay, input int wdelay, input int hold,
                         input bit start_in_out);
      logic [ROW_W-1:0] row, res, exp;
      logic [31:0] mean;
      logic [16:0] inv;
      chk("in_ready_load", o_in_ready, 1);
      row = rand_row();
      i_in_valid = 1'b1; i_in_data = row;
      tick();
      i_in_valid = 1'b0; i_in_data = rand_row();
      chk("stat_start_first", o_stat_start, 1);
      chk("in_ready_stat", o_in_ready, 0);
      for (int c = 0; c < sdelay; c++) begin
         tick();
         chk("stat_start_once", o_stat_start, 0);
      end
      mean = $urandom(); inv = 17'($urandom());
      i_stat_done = 1'b1; i_stat_mean = mean; i_stat_inv_sqrt = inv;
      tick();
      chk("norm_trigger", o_norm_trigger, 1);
      chk("norm_mean", o_norm_mean, mean);
      chk("norm_inv", o_norm_inv_sqrt, inv);
      chk_row("norm_raw", o_norm_raw, row);
      chk("norm_en", o_norm_en, 1);
      i_stat_mean = ~mean; i_stat_inv_sqrt = ~inv;
      tick();
      i_stat_done = 1'b0;
      chk("trigger_one_cycle", o_norm_trigger, 0);
      chk("mean_stable", o_norm_mean, mean);
      chk_row("raw_stable", o_norm_raw, row);
      for (int c = 0; c < wdelay; c++) begin
         tick();
         chk("out_valid_wait", o_out_valid, 0);
      end
      res = rand_row();
      exp_q.push_back(res);
      i_norm_valid = 1'b1; i_norm_data = res;
      tick();
      i_norm_valid = 1'b0; i_norm_data = rand_row();
      exp = exp_q.pop_front();
      chk("out_valid", o_out_valid, 1);
      chk_row("out_data", o_out_data, exp);
      for (int h = 0; h < hold; h++) begin
         if (start_in_out && h == 0) begin
            i_start = 1'b1; i_cfg_rows = 16'd7;
         end
         tick();
         i_start = 1'b0;
         chk("hold_valid", o_out_valid, 1);
         chk_row("hold_data", o_out_data, exp);
         chk("hold_in_ready", o_in_ready, 0);
         chk("hold_row_cnt", o_row_cnt, 16'(idx));
      end
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
      chk("row_cnt_inc", o_row_cnt, 16'(idx + 1));
      chk("out_valid_drop", o_out_valid, 0);
   endtask

   task automatic run_job(input int rows, input int sdelay, input int wdelay, input int hold,
                          input bit start_in_out);
      chk("idle_before_job", o_busy, 0);
      i_start = 1'b1; i_cfg_rows = 16'(rows);
      tick();
      i_start = 1'b0; i_cfg_rows = 16'($urandom());
      chk("busy_after_start", o_busy, 1);
      chk("row_cnt_cleared", o_row_cnt, 0);
      chk("err_cleared", o_err, 0);
      for (int r = 0; r < rows; r++) begin
         chk("no_early_done", o_done, 0);
         do_row(r, sdelay, wdelay, hold, start_in_out && (r == 0));
      end
      chk("done_pulse", o_done, 1);
      tick();
      chk("done_one_cycle", o_done, 0);
      chk("idle_after_job", o_busy, 0);
      chk("final_row_cnt", o_row_cnt, 16'(rows));
   endtask

   initial begin
      logic early;
      i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_cfg_rows = '0;
      i_in_valid = 1'b0; i_in_data = '0; i_stat_done = 1'b0; i_stat_mean = '0;
      i_stat_inv_sqrt = '0; i_norm_valid = 1'b0; i_norm_data = '0; i_out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_err", o_err, 0);
      chk("rst_in_ready", o_in_ready, 0);
      chk("rst_stat_start", o_stat_start, 0);
      chk("rst_norm_en", o_norm_en, 0);
      chk("rst_trigger", o_norm_trigger, 0);
      chk("rst_out_valid", o_out_valid, 0);
      chk("rst_row_cnt", o_row_cnt, 0);
      chk("rst_mean", o_norm_mean, 0);
      chk("rst_inv", o_norm_inv_sqrt, 0);
      chk_row("rst_raw", o_norm_raw, '0);
      chk_row("rst_out_data", o_out_data, '0);
      i_rst_n = 1'b1;
      tick();

      run_job(2, 3, 0, 0, 1'b0);
      run_job(2, $urandom_range(0, 5), $urandom_range(0, 3), 10, 1'b1);

      // Statistics never complete.
      i_start = 1'b1; i_cfg_rows = 16'd1;
      tick();
      i_start = 1'b0;
      i_in_valid = 1'b1; i_in_data = rand_row();
      tick();
      i_in_valid = 1'b0;
      chk("to_stat_start", o_stat_start, 1);
      early = 1'b0;
      for (int c = 1; c < 255; c++) begin
         tick();
         if (o_err !== 1'b0 || o_busy !== 1'b1) early = 1'b1;
      end
      chk("to_not_early", early, 0);
      tick();
      chk("to_err_set", o_err, 1);
      chk("to_idle", o_busy, 0);
      chk("to_no_done", o_done, 0);
      tick();
      chk("to_err_sticky", o_err, 1);
      run_job(1, $urandom_range(0, 5), $urandom_range(0, 3), 0, 1'b0);

      // Abort while waiting on the normalizer, with a coincident result.
      i_start = 1'b1; i_cfg_rows = 16'd2;
      tick();
      i_start = 1'b0;
      i_in_valid = 1'b1; i_in_data = rand_row();
      tick();
      i_in_valid = 1'b0; i_stat_done = 1'b1;
      tick();
      i_stat_done = 1'b0;
      tick();
      chk("ab_busy_wait", o_busy, 1);
      i_abort = 1'b1; i_norm_valid = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("ab_idle", o_busy, 0);
      chk("ab_no_done", o_done, 0);
      chk("ab_no_out", o_out_valid, 0);
      repeat (2) tick();
      i_norm_valid = 1'b0;
      chk("ab_norm_ignored", o_out_valid, 0);
      chk("ab_still_idle", o_busy, 0);
      chk("ab_err_kept", o_err, 0);
      chk("ab_row_cnt", o_row_cnt, 0);

      // Zero-row job.
      i_start = 1'b1; i_cfg_rows = 16'd0;
      tick();
      i_start = 1'b0;
      chk("z_done", o_done, 1);
      chk("z_no_stat", o_stat_start, 0);
      chk("z_no_ready", o_in_ready, 0);
      tick();
      chk("z_done_once", o_done, 0);
      chk("z_idle", o_busy, 0);
      chk("z_no_stat_after", o_stat_start, 0);

      for (int j = 0; j < 3; j++)
         run_job($urandom_range(1, 3), $urandom_range(0, 6), $urandom_range(0, 3),
                 $urandom_range(0, 4), 1'b0);

      // Reset in the middle of a job.
      i_start = 1'b1; i_cfg_rows = 16'd3;
      tick();
      i_start = 1'b0;
      i_in_valid = 1'b1; i_in_data = rand_row();
      tick();
      i_in_valid = 1'b0; i_stat_done = 1'b1; i_stat_mean = 32'hdead_beef;
      tick();
      i_stat_done = 1'b0;
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      chk("mr_idle", o_busy, 0);
      chk("mr_no_done", o_done, 0);
      chk("mr_mean", o_norm_mean, 0);
      chk_row("mr_raw", o_norm_raw, '0);
      tick();
      chk("mr_no_done_after", o_done, 0);
      chk("mr_row_cnt", o_row_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
